// File: rtl/selector_casillas_nxn_if.sv
// Bundle of the button inputs and board/cursor outputs of selector_casillas_nxn.
//   master : drives buttons, enable and clear; observes the board state
//   slave  : the selector itself
interface selector_casillas_nxn_if #(
  parameter int unsigned N    = 3,
  parameter int unsigned IDXW = $clog2(N*N+1)
);
  logic              btn_up;
  logic              btn_down;
  logic              btn_izq;
  logic              btn_der;
  logic              btn_elige;
  logic              enable;
  logic              clear;
  logic [IDXW-1:0]   cuadro;
  logic [2*N*N-1:0]  tablero;
  logic              turno_p1;
  logic              turno_p2;
  logic              move_ok;
  logic              move_rej;
  logic [IDXW-1:0]   jugadas;
  logic              lleno;

  modport master (
    output btn_up, btn_down, btn_izq, btn_der, btn_elige, enable, clear,
    input  cuadro, tablero, turno_p1, turno_p2, move_ok, move_rej, jugadas, lleno
  );

  modport slave (
    input  btn_up, btn_down, btn_izq, btn_der, btn_elige, enable, clear,
    output cuadro, tablero, turno_p1, turno_p2, move_ok, move_rej, jugadas, lleno
  );
endinterface

// File: rtl/selector_casillas_nxn.sv
// N x N board cell selector: moves a cursor from button edges and commits the
// current player's mark through a two-cycle IDLE/CHECK sequence.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of selector_casillas_nxn_if (buttons, enable, clear in;
//              cuadro, tablero, turn flags, move pulses, jugadas, lleno out)
module selector_casillas_nxn #(
  parameter int unsigned N       = 3,
  parameter bit          WRAP    = 1'b0,
  parameter logic [1:0]  P1_CODE = 2'b11,
  parameter logic [1:0]  P2_CODE = 2'b01,
  parameter int unsigned IDXW    = $clog2(N*N+1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  selector_casillas_nxn_if.slave  bus
);

  localparam int unsigned CELLS = N * N;
  localparam int unsigned CW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CENTRE = CW'(N / 2);
  localparam logic [CW-1:0] LAST   = CW'(N - 1);

  typedef enum logic {S_IDLE, S_CHECK} state_e;

  // Button vector order: {elige, der, izq, down, up}
  localparam int unsigned B_UP = 0, B_DOWN = 1, B_IZQ = 2, B_DER = 3, B_ELIGE = 4;

  state_e              state_q;
  logic [4:0]          prev_q;
  logic [CW-1:0]       row_q, col_q;
  logic [CW-1:0]       row_d, col_d;
  logic [IDXW-1:0]     cuadro_q;
  logic [IDXW-1:0]     sel_idx_q;
  logic [2*CELLS-1:0]  tablero_q, tablero_d;
  logic [IDXW-1:0]     jugadas_q;
  logic                lleno_q;
  logic                turno_p1_q, turno_p2_q;
  logic                move_ok_q, move_rej_q;

  logic [4:0]          btn_vec_c;
  logic [4:0]          edge_c;
  logic                accept_c;
  logic                cell_free_c;
  logic [1:0]          mark_c;

  // 0-based row-major cell index
  function automatic logic [IDXW-1:0] cell_idx(input logic [CW-1:0] r,
                                               input logic [CW-1:0] c);
    return IDXW'(r) * IDXW'(N) + IDXW'(c);
  endfunction

  assign btn_vec_c = {bus.btn_elige, bus.btn_der, bus.btn_izq, bus.btn_down, bus.btn_up};
  assign edge_c    = btn_vec_c & ~prev_q;
  assign accept_c  = (state_q == S_IDLE) && bus.enable;
  assign mark_c    = turno_p1_q ? P1_CODE : P2_CODE;

  // Next cursor position; an elige edge outranks every move edge
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (accept_c && !edge_c[B_ELIGE]) begin
      if (edge_c[B_UP]) begin
        if (row_q == '0) row_d = WRAP ? LAST : row_q;
        else             row_d = row_q - CW'(1);
      end else if (edge_c[B_DOWN]) begin
        if (row_q == LAST) row_d = WRAP ? '0 : row_q;
        else               row_d = row_q + CW'(1);
      end else if (edge_c[B_IZQ]) begin
        if (col_q == '0) col_d = WRAP ? LAST : col_q;
        else             col_d = col_q - CW'(1);
      end else if (edge_c[B_DER]) begin
        if (col_q == LAST) col_d = WRAP ? '0 : col_q;
        else               col_d = col_q + CW'(1);
      end
    end
  end

  // Occupancy of the latched cell and the board with the mark applied
  always_comb begin
    cell_free_c = 1'b0;
    tablero_d   = tablero_q;
    for (int k = 0; k < int'(CELLS); k++) begin
      if (sel_idx_q == IDXW'(k)) begin
        cell_free_c          = (tablero_q[2*k +: 2] == 2'b00);
        tablero_d[2*k +: 2]  = mark_c;
      end
    end
  end

  // Control FSM, cursor, board and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      prev_q     <= '0;
      row_q      <= CENTRE;
      col_q      <= CENTRE;
      cuadro_q   <= cell_idx(CENTRE, CENTRE) + IDXW'(1);
      sel_idx_q  <= '0;
      tablero_q  <= '0;
      jugadas_q  <= '0;
      lleno_q    <= 1'b0;
      turno_p1_q <= 1'b1;
      turno_p2_q <= 1'b0;
      move_ok_q  <= 1'b0;
      move_rej_q <= 1'b0;
    end else begin
      prev_q     <= btn_vec_c;
      move_ok_q  <= 1'b0;
      move_rej_q <= 1'b0;
      if (bus.clear) begin
        // New game; also abandons a pending CHECK
        state_q    <= S_IDLE;
        row_q      <= CENTRE;
        col_q      <= CENTRE;
        cuadro_q   <= cell_idx(CENTRE, CENTRE) + IDXW'(1);
        tablero_q  <= '0;
        jugadas_q  <= '0;
        lleno_q    <= 1'b0;
        turno_p1_q <= 1'b1;
        turno_p2_q <= 1'b0;
      end else begin
        row_q    <= row_d;
        col_q    <= col_d;
        cuadro_q <= cell_idx(row_d, col_d) + IDXW'(1);
        case (state_q)
          S_IDLE: begin
            // A full board swallows the select edge without acting on it
            if (accept_c && edge_c[B_ELIGE] && !lleno_q) begin
              sel_idx_q <= cell_idx(row_q, col_q);
              state_q   <= S_CHECK;
            end
          end
          S_CHECK: begin
            state_q <= S_IDLE;
            if (cell_free_c) begin
              tablero_q  <= tablero_d;
              move_ok_q  <= 1'b1;
              jugadas_q  <= jugadas_q + IDXW'(1);
              lleno_q    <= ((jugadas_q + IDXW'(1)) == IDXW'(CELLS));
              turno_p1_q <= ~turno_p1_q;
              turno_p2_q <= ~turno_p2_q;
            end else begin
              move_rej_q <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.cuadro   = cuadro_q;
  assign bus.tablero  = tablero_q;
  assign bus.turno_p1 = turno_p1_q;
  assign bus.turno_p2 = turno_p2_q;
  assign bus.move_ok  = move_ok_q;
  assign bus.move_rej = move_rej_q;
  assign bus.jugadas  = jugadas_q;
  assign bus.lleno    = lleno_q;

endmodule

// File: tb/tb_selector_casillas_nxn.sv
// Directed bench: a 3x3 clamping selector and a 4x4 wrapping selector.
module tb_selector_casillas_nxn;

  logic clk = 1'b0;
  logic reset_n;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  always #5 clk = ~clk;

  selector_casillas_nxn_if #(.N(3)) b3();
  selector_casillas_nxn_if #(.N(4)) b4();

  selector_casillas_nxn #(.N(3), .WRAP(1'b0)) u3 (.clk(clk), .reset_n(reset_n), .bus(b3.slave));
  selector_casillas_nxn #(.N(4), .WRAP(1'b1)) u4 (.clk(clk), .reset_n(reset_n), .bus(b4.slave));

  localparam int UP = 0, DOWN = 1, IZQ = 2, DER = 3, ELIGE = 4;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Button vector order: {elige, der, izq, down, up}
  task automatic set_btns(input int d, input logic [4:0] v);
    if (d == 3) {b3.btn_elige, b3.btn_der, b3.btn_izq, b3.btn_down, b3.btn_up} = v;
    else        {b4.btn_elige, b4.btn_der, b4.btn_izq, b4.btn_down, b4.btn_up} = v;
  endtask

  // One-cycle press then release; returns two cycles after the edge
  task automatic press(input int d, input int b);
    set_btns(d, 5'(1 << b));
    cyc(1);
    set_btns(d, 5'b0);
    cyc(1);
  endtask

  task automatic pulse_clear();
    b3.clear = 1'b1;
    cyc(1);
    b3.clear = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_btns(3, 5'b0); set_btns(4, 5'b0);
    b3.enable = 1'b1; b3.clear = 1'b0;
    b4.enable = 1'b1; b4.clear = 1'b0;
    #12;
    chk_cnt++; if (b3.cuadro !== 4'd5) $display("FAIL reset_cuadro3: got %0d exp 5", b3.cuadro); else pass_cnt++;
    chk_cnt++; if (b4.cuadro !== 5'd11) $display("FAIL reset_cuadro4: got %0d exp 11", b4.cuadro); else pass_cnt++;
    chk_cnt++; if ({b3.turno_p1, b3.turno_p2} !== 2'b10) $display("FAIL reset_turn: got %b exp 10", {b3.turno_p1, b3.turno_p2}); else pass_cnt++;
    chk_cnt++; if (b3.tablero !== 18'h0) $display("FAIL reset_tablero: got %h exp 0", b3.tablero); else pass_cnt++;
    chk_cnt++; if ({b3.jugadas, b3.lleno, b3.move_ok, b3.move_rej} !== 7'b0) $display("FAIL reset_counters: got %b exp 0", {b3.jugadas, b3.lleno, b3.move_ok, b3.move_rej}); else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    cyc(2);
    chk_cnt++; if (b3.cuadro !== 4'd5) $display("FAIL post_reset_cuadro: got %0d exp 5", b3.cuadro); else pass_cnt++;
  endtask

  task automatic test_clamp();
    int exp_c [7] = '{2, 2, 2, 1, 1, 4, 5};
    int btn_s [7] = '{UP, UP, UP, IZQ, IZQ, DOWN, DER};
    for (int i = 0; i < 7; i++) begin
      press(3, btn_s[i]);
      chk_cnt++; if (b3.cuadro !== 4'(exp_c[i])) $display("FAIL clamp_step%0d: got %0d exp %0d", i, b3.cuadro, exp_c[i]); else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    int exp_c [4] = '{12, 9, 13, 1};
    int btn_s [4] = '{DER, DER, DOWN, DOWN};
    for (int i = 0; i < 4; i++) begin
      press(4, btn_s[i]);
      chk_cnt++; if (b4.cuadro !== 5'(exp_c[i])) $display("FAIL wrap_step%0d: got %0d exp %0d", i, b4.cuadro, exp_c[i]); else pass_cnt++;
    end
  endtask

  task automatic test_mark_reject();
    set_btns(3, 5'b10000);
    cyc(1);
    chk_cnt++; if (b3.move_ok !== 1'b0) $display("FAIL mark_early: got %b exp 0", b3.move_ok); else pass_cnt++;
    set_btns(3, 5'b0);
    cyc(1);
    chk_cnt++; if (b3.move_ok !== 1'b1) $display("FAIL mark_ok: got %b exp 1", b3.move_ok); else pass_cnt++;
    chk_cnt++; if (b3.tablero !== 18'h00300) $display("FAIL mark_tablero: got %h exp 00300", b3.tablero); else pass_cnt++;
    chk_cnt++; if ({b3.turno_p1, b3.turno_p2} !== 2'b01) $display("FAIL mark_turn: got %b exp 01", {b3.turno_p1, b3.turno_p2}); else pass_cnt++;
    chk_cnt++; if (b3.jugadas !== 4'd1) $display("FAIL mark_jugadas: got %0d exp 1", b3.jugadas); else pass_cnt++;
    press(3, ELIGE);
    chk_cnt++; if ({b3.move_rej, b3.move_ok} !== 2'b10) $display("FAIL reject_pulse: got %b exp 10", {b3.move_rej, b3.move_ok}); else pass_cnt++;
    chk_cnt++; if (b3.tablero !== 18'h00300) $display("FAIL reject_tablero: got %h exp 00300", b3.tablero); else pass_cnt++;
    chk_cnt++; if (b3.turno_p2 !== 1'b1) $display("FAIL reject_turn: got %b exp 1", b3.turno_p2); else pass_cnt++;
    cyc(1);
    chk_cnt++; if (b3.move_rej !== 1'b0) $display("FAIL reject_one_cycle: got %b exp 0", b3.move_rej); else pass_cnt++;
  endtask

  task automatic test_simultaneous_dropped();
    pulse_clear();
    set_btns(3, 5'b11000);
    cyc(1);
    chk_cnt++; if (b3.cuadro !== 4'd5) $display("FAIL simul_cursor: got %0d exp 5", b3.cuadro); else pass_cnt++;
    set_btns(3, 5'b0);
    cyc(1);
    chk_cnt++; if ({b3.move_ok, b3.tablero} !== {1'b1, 18'h00300}) $display("FAIL simul_mark: got %b/%h exp 1/00300", b3.move_ok, b3.tablero); else pass_cnt++;
    press(3, IZQ);
    chk_cnt++; if (b3.cuadro !== 4'd4) $display("FAIL simul_move: got %0d exp 4", b3.cuadro); else pass_cnt++;
    set_btns(3, 5'b10000);
    cyc(1);
    set_btns(3, 5'b01000);
    cyc(1);
    chk_cnt++; if (b3.move_ok !== 1'b1) $display("FAIL drop_ok: got %b exp 1", b3.move_ok); else pass_cnt++;
    set_btns(3, 5'b0);
    cyc(1);
    chk_cnt++; if (b3.cuadro !== 4'd4) $display("FAIL drop_cursor: got %0d exp 4", b3.cuadro); else pass_cnt++;
    chk_cnt++; if (b3.tablero !== 18'h00340) $display("FAIL drop_tablero: got %h exp 00340", b3.tablero); else pass_cnt++;
    chk_cnt++; if ({b3.turno_p1, b3.jugadas} !== {1'b1, 4'd2}) $display("FAIL drop_turn_count: got %b/%0d exp 1/2", b3.turno_p1, b3.jugadas); else pass_cnt++;
  endtask

  task automatic test_enable();
    b3.enable = 1'b0;
    press(3, DER);
    chk_cnt++; if (b3.cuadro !== 4'd4) $display("FAIL disabled_move: got %0d exp 4", b3.cuadro); else pass_cnt++;
    press(3, ELIGE);
    chk_cnt++; if ({b3.move_ok, b3.move_rej} !== 2'b00) $display("FAIL disabled_select: got %b exp 00", {b3.move_ok, b3.move_rej}); else pass_cnt++;
    b3.enable = 1'b1;
    set_btns(3, 5'b10000);
    cyc(1);
    b3.enable = 1'b0;
    set_btns(3, 5'b0);
    cyc(1);
    chk_cnt++; if ({b3.move_ok, b3.move_rej} !== 2'b01) $display("FAIL check_completes: got %b exp 01", {b3.move_ok, b3.move_rej}); else pass_cnt++;
    b3.enable = 1'b1;
  endtask

  task automatic test_fill_clear();
    int seq [17] = '{ELIGE, DER, ELIGE, DER, ELIGE, DOWN, ELIGE, IZQ, ELIGE,
                     IZQ, ELIGE, DOWN, ELIGE, DER, ELIGE, DER, ELIGE};
    int ord [9]  = '{1, 2, 3, 6, 5, 4, 7, 8, 9};
    logic [17:0] exp_t;
    int n;
    exp_t = '0;
    for (int i = 0; i < 9; i++) exp_t[2*(ord[i]-1) +: 2] = (i % 2 == 0) ? 2'b11 : 2'b01;
    pulse_clear();
    press(3, UP);
    press(3, IZQ);
    chk_cnt++; if (b3.cuadro !== 4'd1) $display("FAIL fill_start: got %0d exp 1", b3.cuadro); else pass_cnt++;
    n = 0;
    for (int i = 0; i < 17; i++) begin
      press(3, seq[i]);
      if (seq[i] == ELIGE) begin
        n++;
        chk_cnt++; if (b3.move_ok !== 1'b1) $display("FAIL fill_ok%0d: got %b exp 1", n, b3.move_ok); else pass_cnt++;
        if (n == 8) begin
          chk_cnt++; if (b3.lleno !== 1'b0) $display("FAIL lleno_early: got %b exp 0", b3.lleno); else pass_cnt++;
        end
      end
    end
    chk_cnt++; if ({b3.jugadas, b3.lleno} !== {4'd9, 1'b1}) $display("FAIL full_count: got %0d/%b exp 9/1", b3.jugadas, b3.lleno); else pass_cnt++;
    chk_cnt++; if (b3.tablero !== exp_t) $display("FAIL full_tablero: got %h exp %h", b3.tablero, exp_t); else pass_cnt++;
    chk_cnt++; if (b3.turno_p1 !== 1'b0) $display("FAIL full_turn: got %b exp 0", b3.turno_p1); else pass_cnt++;
    press(3, ELIGE);
    cyc(1);
    chk_cnt++; if ({b3.move_ok, b3.move_rej, b3.jugadas} !== {2'b00, 4'd9}) $display("FAIL full_ignored: got %b%b/%0d exp 00/9", b3.move_ok, b3.move_rej, b3.jugadas); else pass_cnt++;
    pulse_clear();
    chk_cnt++; if ({b3.tablero, b3.cuadro} !== {18'h0, 4'd5}) $display("FAIL clear_board: got %h/%0d exp 0/5", b3.tablero, b3.cuadro); else pass_cnt++;
    chk_cnt++; if ({b3.turno_p1, b3.turno_p2, b3.jugadas, b3.lleno} !== {2'b10, 4'd0, 1'b0}) $display("FAIL clear_state: got %b%b/%0d/%b exp 10/0/0", b3.turno_p1, b3.turno_p2, b3.jugadas, b3.lleno); else pass_cnt++;
    set_btns(3, 5'b10000);
    cyc(1);
    b3.clear = 1'b1;
    set_btns(3, 5'b0);
    cyc(1);
    chk_cnt++; if ({b3.move_ok, b3.move_rej} !== 2'b00) $display("FAIL clear_mid_pulse: got %b exp 00", {b3.move_ok, b3.move_rej}); else pass_cnt++;
    chk_cnt++; if ({b3.tablero, b3.jugadas, b3.turno_p1} !== {18'h0, 4'd0, 1'b1}) $display("FAIL clear_mid_state: got %h/%0d/%b exp 0/0/1", b3.tablero, b3.jugadas, b3.turno_p1); else pass_cnt++;
    b3.clear = 1'b0;
    cyc(1);
    chk_cnt++; if ({b3.move_ok, b3.tablero} !== {1'b0, 18'h0}) $display("FAIL clear_mid_after: got %b/%h exp 0/0", b3.move_ok, b3.tablero); else pass_cnt++;
  endtask

  task automatic test_reset_mid_check();
    set_btns(3, 5'b10000);
    cyc(1);
    reset_n = 1'b0;
    set_btns(3, 5'b0);
    #2;
    chk_cnt++; if ({b3.tablero, b3.move_ok} !== {18'h0, 1'b0}) $display("FAIL rst_mid_async: got %h/%b exp 0/0", b3.tablero, b3.move_ok); else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    cyc(2);
    chk_cnt++; if ({b3.tablero, b3.jugadas, b3.move_ok} !== {18'h0, 4'd0, 1'b0}) $display("FAIL rst_mid_after: got %h/%0d/%b exp 0/0/0", b3.tablero, b3.jugadas, b3.move_ok); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_clamp();
    test_wrap();
    test_mark_reject();
    test_simultaneous_dropped();
    test_enable();
    test_fill_clear();
    test_reset_mid_check();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
